// File: rtl/pwm_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_gen
//  Purpose  : 16-phase PWM generator with a programmable clock prescaler.
//             A prescaler divides clk into phase steps; a 4-bit phase
//             counter walks through one 16-step period.  pwm_out is high
//             while phase < duty_active, giving 0/16 .. 15/16 duty.
//             period_start pulses for one cycle after the 15->0 wrap.
//  Options  : PWM_SYNC_LOAD_EN -- when defined, duty_active is reloaded
//             from duty only at the period wrap (and whenever enable=0),
//             so mid-period duty changes cannot glitch the waveform.
//             When undefined, duty_active follows duty every clock.
//  Revision : 1.0  initial release
// ============================================================================
module pwm_gen #(
  parameter int PRESCALE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] duty,
  output logic       pwm_out,
  output logic       period_start,
  output logic [3:0] duty_active
);

  // Prescaler width: at least one bit so PRESCALE=1 still has a legal vector.
  localparam int                 c_PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(PRESCALE - 1);
  localparam logic [3:0]         c_PH_LAST = 4'd15;

  // Reject out-of-range prescale values at elaboration time.
  generate
    if ((PRESCALE < 1) || (PRESCALE > 256)) begin : g_bad_prescale
      $error("pwm_gen: PRESCALE must be in 1..256");
    end
  endgenerate

  logic [c_PRE_W-1:0] r_pre_cnt;
  logic [3:0]         r_phase;
  logic [3:0]         r_duty_active;
  logic               r_pwm;
  logic               r_period_start;

  logic               w_step;
  logic               w_wrap;
  logic               w_load;
  logic               w_pwm_next;

  // Step and wrap qualification from the current (pre-edge) state.
  always_comb begin
    w_step     = enable && (r_pre_cnt == c_PRE_MAX);
    w_wrap     = w_step && (r_phase == c_PH_LAST);
    w_pwm_next = enable && (r_phase < r_duty_active);
`ifdef PWM_SYNC_LOAD_EN
    w_load     = w_wrap || !enable;
`else
    w_load     = 1'b1;
`endif
  end

  // Prescaler: counts enabled cycles, wraps to zero on each phase step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre_cnt <= '0;
    end else if (enable) begin
      if (w_step) begin
        r_pre_cnt <= '0;
      end else begin
        r_pre_cnt <= r_pre_cnt + 1'b1;
      end
    end
  end

  // Phase counter: advances once per step, natural 4-bit wrap 15->0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase <= 4'd0;
    end else if (w_step) begin
      r_phase <= r_phase + 4'd1;
    end
  end

  // Applied duty register; load timing depends on the sync-load option.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_duty_active <= 4'd0;
    end else if (w_load) begin
      r_duty_active <= duty;
    end
  end

  // Output registers: waveform lags phase by one cycle; wrap pulse likewise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pwm          <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      r_pwm          <= w_pwm_next;
      r_period_start <= w_wrap;
    end
  end

  assign pwm_out      = r_pwm;
  assign period_start = r_period_start;
  assign duty_active  = r_duty_active;

endmodule
`default_nettype wire

// File: tb/tb_pwm_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_gen
//  Purpose  : Scoreboard bench for pwm_gen.  Two instances (PRESCALE=1 and
//             PRESCALE=3) share stimulus.  A reference model derives the
//             phase from the number of enabled cycles since reset and
//             queues the expected registered outputs; a monitor pops and
//             compares after every rising edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pwm_gen;

  typedef struct packed {
    logic       pwm;
    logic       ps;
    logic [3:0] da;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [3:0] duty;

  logic       pwm1, ps1;
  logic [3:0] da1;
  logic       pwm3, ps3;
  logic [3:0] da3;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t q1[$];
  exp_t q3[$];

  // Model state: enabled cycles since reset, and applied duty, per instance.
  int         ecnt[2];
  logic [3:0] mda[2];

  pwm_gen #(.PRESCALE(1)) u_dut1 (
    .clk(clk), .rst(rst), .enable(enable), .duty(duty),
    .pwm_out(pwm1), .period_start(ps1), .duty_active(da1)
  );

  pwm_gen #(.PRESCALE(3)) u_dut3 (
    .clk(clk), .rst(rst), .enable(enable), .duty(duty),
    .pwm_out(pwm3), .period_start(ps3), .duty_active(da3)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs after the coming rising edge, for an instance with
  // prescale p, given the inputs currently applied.
  task automatic model_cycle(input int k, input int p, output exp_t e);
    int  ph;
    bit  stp;
    bit  wrap;
    if (!rst) begin
      ecnt[k] = 0;
      mda[k]  = 4'd0;
      e       = '0;
      return;
    end
    ph   = (ecnt[k] / p) % 16;
    stp  = enable && ((ecnt[k] % p) == (p - 1));
    wrap = stp && (ph == 15);
    e.pwm = enable && (ph < int'(mda[k]));
    e.ps  = wrap;
`ifdef PWM_SYNC_LOAD_EN
    if (wrap || !enable) mda[k] = duty;
`else
    mda[k] = duty;
`endif
    e.da = mda[k];
    if (enable) ecnt[k]++;
  endtask

  task automatic push_expect();
    exp_t e;
    model_cycle(0, 1, e);
    q1.push_back(e);
    model_cycle(1, 3, e);
    q3.push_back(e);
  endtask

  task automatic drive_cycle(input logic r, input logic en, input logic [3:0] d);
    @(negedge clk);
    rst    = r;
    enable = en;
    duty   = d;
    push_expect();
  endtask

  task automatic run(input int n, input logic en, input logic [3:0] d);
    for (int i = 0; i < n; i++) drive_cycle(1'b1, en, d);
  endtask

  // Reset asserted between edges: outputs must clear before any clock edge.
  task automatic mid_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_pwm1", pwm1, 0);
    chk("async_rst_ps1",  ps1,  0);
    chk("async_rst_da1",  da1,  0);
    chk("async_rst_pwm3", pwm3, 0);
    chk("async_rst_ps3",  ps3,  0);
    chk("async_rst_da3",  da3,  0);
    push_expect();
  endtask

  // Monitor: one expected entry per rising edge for each instance.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q1.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL q1_underflow: got empty queue expected entry at %0t", $time);
      end else begin
        e = q1.pop_front();
        chk("p1_pwm_out",      pwm1, e.pwm);
        chk("p1_period_start", ps1,  e.ps);
        chk("p1_duty_active",  da1,  e.da);
      end
      if (q3.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL q3_underflow: got empty queue expected entry at %0t", $time);
      end else begin
        e = q3.pop_front();
        chk("p3_pwm_out",      pwm3, e.pwm);
        chk("p3_period_start", ps3,  e.ps);
        chk("p3_duty_active",  da3,  e.da);
      end
    end
  end

  // Stimulus
  initial begin
    logic [3:0] rd;
    logic       ren;
    rst    = 1'b0;
    enable = 1'b0;
    duty   = 4'd0;
    #1;
    chk("reset_pwm1", pwm1, 0);
    chk("reset_ps1",  ps1,  0);
    chk("reset_da1",  da1,  0);
    chk("reset_pwm3", pwm3, 0);
    chk("reset_ps3",  ps3,  0);
    chk("reset_da3",  da3,  0);

    drive_cycle(1'b0, 1'b0, 4'd0);
    drive_cycle(1'b0, 1'b0, 4'd0);

    // Preload duty 4 while disabled, then run several periods.
    run(2, 1'b0, 4'd4);
    run(22, 1'b1, 4'd4);
    // Mid-period duty change (phase 6 on the PRESCALE=1 instance).
    run(40, 1'b1, 4'd12);

    // Extremes of duty.
    run(64, 1'b1, 4'd0);
    run(64, 1'b1, 4'd15);

    // Pause mid-period for 10 cycles, then resume.
    run(7, 1'b1, 4'd8);
    run(10, 1'b0, 4'd8);
    run(40, 1'b1, 4'd8);

    // Long run at duty 8 spans several 48-cycle periods for PRESCALE=3.
    run(120, 1'b1, 4'd8);

    // Asynchronous reset mid-period, then restart.
    run(5, 1'b1, 4'd8);
    mid_reset();
    drive_cycle(1'b0, 1'b1, 4'd8);
    run(60, 1'b1, 4'd8);

    // Randomized traffic.
    rd = 4'd5;
    for (int i = 0; i < 1500; i++) begin
      ren = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) rd = 4'($urandom_range(0, 15));
      if (i == 700) begin
        mid_reset();
        drive_cycle(1'b0, ren, rd);
      end else begin
        drive_cycle(1'b1, ren, rd);
      end
    end

    @(posedge clk);
    #3;
    chk("q1_drained", q1.size(), 0);
    chk("q3_drained", q3.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
